slowctrl_link_responder: RTL and testbench

//  Slow-FPGA end of the Zynq<->slow-FPGA serial control link. Deserialises register-write

---
 rtl/slowctrl_pkg.sv | 15 +
 rtl/slowctrl_tx_serialiser.sv | 88 ++++++++
 rtl/slowctrl_link_responder.sv | 128 ++++++++++++
 tb/tb_slowctrl_link_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/slowctrl_pkg.sv
// slowctrl_pkg: shared widths, frame length and FSM state types for the slow-control link (SLOWCTRL_PARITY_EN adds a parity bit)
package slowctrl_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
`ifdef SLOWCTRL_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  function automatic int frame_len(input int aw, input int dw);
    return 1 + aw + dw + PAR_BITS;
  endfunction
  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_DONE} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_GAP} tx_state_t;
endpackage

// File: rtl/slowctrl_tx_serialiser.sv
// slowctrl_tx_serialiser: status frame divider, shift register and TX FSM (SLOWCTRL_PARITY_EN appends even parity)
module slowctrl_tx_serialiser import slowctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CLK_DIV = 25,
  parameter int GAP_N = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              sclk_o,
  output logic              dat_o
);
  localparam int N = frame_len(ADDR_W, DATA_W);
  localparam int CW = $clog2((N > GAP_N ? N : GAP_N) + 1);
  localparam int DW = $clog2(CLK_DIV);
  tx_state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic hi_q, hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] sr_q, sr_d, frame;
  logic ready_q, sclk_q, dat_q;
  logic half_end, per_end;
`ifdef SLOWCTRL_PARITY_EN
  assign frame = {1'b1, addr_i, data_i, ^{addr_i, data_i}};
`else
  assign frame = {1'b1, addr_i, data_i};
`endif
  assign half_end = div_q == DW'(CLK_DIV - 1);
  assign per_end = half_end && hi_q;
  assign ready_o = ready_q;
  assign sclk_o = sclk_q;
  assign dat_o = dat_q;
  // next state: each period is CLK_DIV low then CLK_DIV high; data advances on the fall
  always_comb begin
    state_d = state_q;
    div_d = '0;
    hi_d = 1'b0;
    cnt_d = cnt_q;
    sr_d = sr_q;
    if (state_q == TX_IDLE) begin
      if (valid_i && ready_q) begin
        state_d = TX_SHIFT;
        cnt_d = '0;
        sr_d = frame;
      end
    end else begin
      div_d = half_end ? '0 : div_q + 1'b1;
      hi_d = hi_q ^ half_end;
      if (per_end) begin
        cnt_d = cnt_q + 1'b1;
        sr_d = sr_q << 1;
        if (state_q == TX_SHIFT && cnt_q == CW'(N - 1)) begin
          state_d = GAP_N > 0 ? TX_GAP : TX_IDLE;
          cnt_d = '0;
        end else if (state_q == TX_GAP && cnt_q == CW'(GAP_N - 1)) begin
          state_d = TX_IDLE;
          cnt_d = '0;
        end
      end
    end
  end
  // state and registered, glitch-free serial outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= TX_IDLE;
      div_q <= '0;
      hi_q <= 1'b0;
      cnt_q <= '0;
      sr_q <= '0;
      ready_q <= 1'b0;
      sclk_q <= 1'b0;
      dat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      hi_q <= hi_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      ready_q <= state_d == TX_IDLE;
      sclk_q <= state_d == TX_SHIFT && hi_d;
      dat_q <= state_d == TX_SHIFT && sr_d[N-1];
    end
  end
endmodule

// File: rtl/slowctrl_link_responder.sv
// slowctrl_link_responder: slow-FPGA end of the serial control link, RX write frames and TX status frames (SLOWCTRL_PARITY_EN adds parity)
module slowctrl_link_responder #(
  parameter int ADDR_W = slowctrl_pkg::ADDR_W_DEF,
  parameter int DATA_W = slowctrl_pkg::DATA_W_DEF,
  parameter int CLK_DIV = 25,
  parameter int RX_TIMEOUT = 256,
  parameter int TX_GAP = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              spi_sclk_i,
  input  logic              spi_dat_i,
  output logic              spi_sclk_o,
  output logic              spi_dat_o,
  output logic              wr_strobe_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              rx_err_o,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [ADDR_W-1:0] tx_addr_i,
  input  logic [DATA_W-1:0] tx_data_i
);
  import slowctrl_pkg::*;
  localparam int N = frame_len(ADDR_W, DATA_W);
  localparam int P = N - 1;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  rx_state_t rx_state_q, rx_state_d;
  logic [1:0] sclk_sync_q, dat_sync_q;
  logic sclk_prev_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [P-1:0] rx_sr_q, rx_sr_d;
  logic [TW-1:0] to_q, to_d;
  logic strobe_q, strobe_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic rise, bit_in, par_ok;
  assign rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign bit_in = dat_sync_q[1];
`ifdef SLOWCTRL_PARITY_EN
  assign par_ok = ~^rx_sr_q;
`else
  assign par_ok = 1'b1;
`endif
  assign wr_strobe_o = strobe_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;
  assign rx_err_o = err_q;
  // RX next state: hunt for start bit, shift payload, then publish or abort
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d = rx_cnt_q;
    rx_sr_d = rx_sr_q;
    to_d = '0;
    strobe_d = 1'b0;
    err_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    case (rx_state_q)
      RX_IDLE: if (rise && bit_in) begin
        rx_state_d = RX_SHIFT;
        rx_cnt_d = '0;
      end
      RX_SHIFT: if (rise) begin
        rx_sr_d = {rx_sr_q[P-2:0], bit_in};
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CW'(P - 1)) rx_state_d = RX_DONE;
      end else if (to_q == TW'(RX_TIMEOUT - 1)) begin
        err_d = 1'b1;
        rx_state_d = RX_IDLE;
      end else begin
        to_d = to_q + 1'b1;
      end
      RX_DONE: begin
        rx_state_d = RX_IDLE;
        strobe_d = par_ok;
        err_d = ~par_ok;
        addr_d = par_ok ? rx_sr_q[P-1 -: ADDR_W] : addr_q;
        data_d = par_ok ? rx_sr_q[P-1-ADDR_W -: DATA_W] : data_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end
  // RX synchronisers, edge history, state and held write outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sclk_sync_q <= '0;
      dat_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_sr_q <= '0;
      to_q <= '0;
      strobe_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
      dat_sync_q <= {dat_sync_q[0], spi_dat_i};
      sclk_prev_q <= sclk_sync_q[1];
      rx_state_q <= rx_state_d;
      rx_cnt_q <= rx_cnt_d;
      rx_sr_q <= rx_sr_d;
      to_q <= to_d;
      strobe_q <= strobe_d;
      err_q <= err_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  slowctrl_tx_serialiser #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CLK_DIV(CLK_DIV),
    .GAP_N(TX_GAP)
  ) u_tx (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .valid_i(tx_valid_i),
    .addr_i(tx_addr_i),
    .data_i(tx_data_i),
    .ready_o(tx_ready_o),
    .sclk_o(spi_sclk_o),
    .dat_o(spi_dat_o)
  );
endmodule

// File: tb/tb_slowctrl_link_responder.sv
// tb_slowctrl_link_responder: randomized self-checking bench with a frame-level reference model
module tb_slowctrl_link_responder;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CD = 25;
  localparam int TO = 256;
  localparam int GAP = 4;
`ifdef SLOWCTRL_PARITY_EN
  localparam int NF = 2 + AW + DW;
`else
  localparam int NF = 1 + AW + DW;
`endif
  logic clk = 0, rst_n = 0, drv_sclk = 0, drv_dat = 0, loop = 0, tx_valid = 0;
  logic spi_sclk_i, spi_dat_i, spi_sclk_o, spi_dat_o, wr_strobe_o, rx_err_o, tx_ready_o;
  logic [AW-1:0] wr_addr_o, tx_addr = '0, last_addr = '0;
  logic [DW-1:0] wr_data_o, tx_data = '0, last_data = '0;
  int checks = 0, errors = 0, n_strobe = 0, n_err = 0, cyc = 0, last_rise = 0, err_cyc = 0;
  logic [AW+DW-1:0] rx_exp[$];
  logic [NF-1:0] tx_exp[$];
  logic [NF-1:0] txsh = '0;
  int txn = 0;
  logic sclk_prev = 0;

  assign spi_sclk_i = loop ? spi_sclk_o : drv_sclk;
  assign spi_dat_i = loop ? spi_dat_o : drv_dat;

  slowctrl_link_responder dut (
    .clk_i(clk), .reset_i(rst_n), .spi_sclk_i(spi_sclk_i), .spi_dat_i(spi_dat_i),
    .spi_sclk_o(spi_sclk_o), .spi_dat_o(spi_dat_o), .wr_strobe_o(wr_strobe_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .rx_err_o(rx_err_o),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o), .tx_addr_i(tx_addr), .tx_data_i(tx_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NF-1:0] mk_frame(input logic [AW-1:0] a, input logic [DW-1:0] d);
`ifdef SLOWCTRL_PARITY_EN
    return {1'b1, a, d, ^{a, d}};
`else
    return {1'b1, a, d};
`endif
  endfunction

  // observe write strobes, errors and decode the TX line independently of the DUT
  always @(negedge clk) begin
    if (!rst_n) begin
      txn = 0;
      sclk_prev = 0;
    end else begin
      if (spi_sclk_o && !sclk_prev) begin
        txsh = {txsh[NF-2:0], spi_dat_o};
        txn++;
        if (txn == NF) begin
          txn = 0;
          chk("tx_exp_avail", tx_exp.size() != 0, 1);
          if (tx_exp.size() != 0) chk("tx_frame", txsh, tx_exp.pop_front());
        end
      end
      sclk_prev = spi_sclk_o;
      if (wr_strobe_o) begin
        n_strobe++;
        chk("rx_exp_avail", rx_exp.size() != 0, 1);
        if (rx_exp.size() != 0) begin
          logic [AW+DW-1:0] e;
          e = rx_exp.pop_front();
          chk("wr_addr", wr_addr_o, e[AW+DW-1:DW]);
          chk("wr_data", wr_data_o, e[DW-1:0]);
          last_addr = wr_addr_o;
          last_data = wr_data_o;
        end
      end
      if (rx_err_o) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end

  task automatic send_rx(input logic [AW-1:0] a, input logic [DW-1:0] d, input int nb, input int hp, input bit flip);
    logic [NF-1:0] f;
    f = mk_frame(a, d);
    if (flip) f[0] = ~f[0];
    for (int i = 0; i < nb; i++) begin
      drv_dat = f[NF-1-i];
      repeat (hp) @(negedge clk);
      drv_sclk = 1;
      last_rise = cyc;
      repeat (hp) @(negedge clk);
      drv_sclk = 0;
    end
    drv_dat = 0;
  endtask

  task automatic rx_frame(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hp);
    rx_exp.push_back({a, d});
    send_rx(a, d, NF, hp, 0);
  endtask

  task automatic wait_strobes(input int tgt);
    for (int i = 0; i < 400 && n_strobe < tgt; i++) @(negedge clk);
    chk("strobe_cnt", n_strobe, tgt);
  endtask

  task automatic tx_send(input logic [AW-1:0] a, input logic [DW-1:0] d, output int low);
    for (int i = 0; i < 100 && !tx_ready_o; i++) @(negedge clk);
    tx_addr = a;
    tx_data = d;
    tx_valid = 1;
    tx_exp.push_back(mk_frame(a, d));
    @(negedge clk);
    low = 0;
    while (!tx_ready_o && low < 6000) begin
      low++;
      tx_valid = 1'($urandom_range(0, 1));
      tx_addr = AW'($urandom);
      tx_data = $urandom;
      @(negedge clk);
    end
    tx_valid = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int low, s, e0, r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    repeat (3) @(negedge clk);
    chk("rst_outs", {wr_strobe_o, rx_err_o, spi_sclk_o, spi_dat_o, wr_addr_o, wr_data_o}, 0);
    chk("rst_ready", tx_ready_o, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", tx_ready_o, 1);

    rx_frame(10'h3AA, 32'h55AA55AA, 4);
    wait_strobes(1);
    chk("t1_no_err", n_err, 0);

    rx_frame(10'h355, 32'hAA55AA55, 3);
    rx_frame(10'h001, 32'h00000001, 3);
    wait_strobes(3);

    for (int k = 0; k < 8; k++) begin
      a = AW'($urandom);
      d = $urandom;
      rx_frame(a, d, $urandom_range(2, 6));
      wait_strobes(4 + k);
    end

    s = n_strobe;
    e0 = n_err;
    send_rx(AW'($urandom), $urandom, 20, 4, 0);
    r = last_rise;
    for (int i = 0; i < TO + 50 && n_err == e0; i++) @(negedge clk);
    chk("to_err_cnt", n_err, e0 + 1);
    chk("to_latency_ok", (err_cyc - r >= TO) && (err_cyc - r <= TO + 4), 1);
    chk("to_no_strobe", n_strobe, s);
    rx_frame(10'h0F0, 32'hCAFEF00D, 5);
    wait_strobes(s + 1);

    loop = 1;
    rx_exp.push_back({10'h2A5, 32'hDEADBEEF});
    tx_send(10'h2A5, 32'hDEADBEEF, low);
    chk("tx_ready_low", low, (NF + GAP) * 2 * CD);
    wait_strobes(s + 2);
    for (int k = 0; k < 3; k++) begin
      a = AW'($urandom);
      d = $urandom;
      rx_exp.push_back({a, d});
      tx_send(a, d, low);
      chk("tx_ready_low_rnd", low, (NF + GAP) * 2 * CD);
      wait_strobes(s + 3 + k);
    end
    chk("tx_all_seen", tx_exp.size(), 0);
    loop = 0;

    s = n_strobe;
    e0 = n_err;
    tx_addr = 10'h111;
    tx_data = 32'h01234567;
    tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    send_rx(10'h155, 32'h12345678, 15, 4, 0);
    #2 rst_n = 0;
    #1;
    chk("async_rst_outs", {wr_strobe_o, rx_err_o, spi_sclk_o, spi_dat_o, wr_addr_o, wr_data_o}, 0);
    chk("async_rst_ready", tx_ready_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst2", tx_ready_o, 1);
    repeat (TO + 20) @(negedge clk);
    chk("rst_no_strobe", n_strobe, s);
    chk("rst_no_err", n_err, e0);
    chk("rst_tx_idle", {spi_sclk_o, spi_dat_o}, 0);
    rx_frame(10'h3AA, 32'h55AA55AA, 4);
    wait_strobes(s + 1);

`ifdef SLOWCTRL_PARITY_EN
    s = n_strobe;
    e0 = n_err;
    a = last_addr;
    d = last_data;
    send_rx(AW'($urandom), $urandom, NF, 4, 1);
    for (int i = 0; i < 100 && n_err == e0; i++) @(negedge clk);
    chk("par_err", n_err, e0 + 1);
    chk("par_no_strobe", n_strobe, s);
    chk("par_hold", {wr_addr_o, wr_data_o}, {a, d});
`endif

    chk("rx_all_seen", rx_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
